// File: rtl/mips_alu_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: decodes one instruction into ALU controls
// and steps it through the FETCH, DECODE, EXEC, MEM and WB states.
module mips_alu_ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  alu_op,
  output logic [4:0]  shamt,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [31:0] imm_ext,
  output logic        alu_src_imm,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic        pc_jr,
  output logic        instr_done,
  output logic        illegal
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_NOR   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_JR    = 5'd11;
  localparam logic [4:0] OP_NOP   = 5'd12;
  localparam logic [4:0] OP_ANDI  = 5'd13;
  localparam logic [4:0] OP_ORI   = 5'd14;
  localparam logic [4:0] OP_SLTI  = 5'd15;
  localparam logic [4:0] OP_ADDI  = 5'd16;
  localparam logic [4:0] OP_ADDIU = 5'd17;
  localparam logic [4:0] OP_LW    = 5'd18;
  localparam logic [4:0] OP_SW    = 5'd19;
  localparam logic [4:0] OP_LUI   = 5'd20;

  logic [2:0]  state, state_nx;
  logic [31:0] instr_q;

  logic [5:0]  opc, funct;
  logic [31:0] sext, zext;
  logic [4:0]  d_op, d_waddr;
  logic [31:0] d_imm;
  logic        d_src, d_ill, d_lw, d_sw, d_jr, d_nop;
  logic        k_lw, k_sw, k_jr, k_nop;

  assign opc   = instr_q[31:26];
  assign funct = instr_q[5:0];
  assign sext  = {{16{instr_q[15]}}, instr_q[15:0]};
  assign zext  = {16'h0000, instr_q[15:0]};

  always_comb begin
    d_op    = OP_NOP;
    d_imm   = '0;
    d_src   = 1'b0;
    d_waddr = instr_q[20:16];
    d_ill   = 1'b0;
    d_lw    = 1'b0;
    d_sw    = 1'b0;
    d_jr    = 1'b0;
    d_nop   = 1'b0;
    if (opc == 6'h00) begin
      d_waddr = instr_q[15:11];
      case (funct)
        6'h20: d_op = OP_ADD;
        6'h21: d_op = OP_ADDU;
        6'h22: d_op = OP_SUB;
        6'h23: d_op = OP_SUBU;
        6'h24: d_op = OP_AND;
        6'h25: d_op = OP_OR;
        6'h27: d_op = OP_NOR;
        6'h2A: d_op = OP_SLT;
        6'h02: d_op = OP_SRL;
        6'h03: d_op = OP_SRA;
        6'h08: begin
          d_op = OP_JR;
          d_jr = 1'b1;
        end
        // the all-zero word is the canonical nop, not sll $0,$0,0
        6'h00: begin
          d_nop = (instr_q == 32'h0);
          d_op  = d_nop ? OP_NOP : OP_SLL;
        end
        default: d_ill = 1'b1;
      endcase
    end else begin
      d_src = 1'b1;
      case (opc)
        6'h08: begin d_op = OP_ADDI;  d_imm = sext; end
        6'h09: begin d_op = OP_ADDIU; d_imm = sext; end
        6'h0A: begin d_op = OP_SLTI;  d_imm = sext; end
        6'h0C: begin d_op = OP_ANDI;  d_imm = zext; end
        6'h0D: begin d_op = OP_ORI;   d_imm = zext; end
        6'h0F: begin d_op = OP_LUI;   d_imm = zext; end
        6'h23: begin
          d_op = OP_LW;
          d_imm = sext;
          d_lw = 1'b1;
        end
        6'h2B: begin
          d_op = OP_SW;
          d_imm = sext;
          d_sw = 1'b1;
        end
        default: d_ill = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:  if (instr_valid) state_nx = DECODE;
      DECODE: state_nx = d_ill ? FETCH : EXEC;
      EXEC: begin
        unique case (1'b1)
          k_lw, k_sw:   state_nx = MEM;
          k_jr, k_nop:  state_nx = FETCH;
          default:      state_nx = WB;
        endcase
      end
      MEM:    if (mem_ack) state_nx = k_lw ? WB : FETCH;
      WB:     state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      instr_q     <= '0;
      alu_op      <= OP_NOP;
      shamt       <= '0;
      rs_addr     <= '0;
      rt_addr     <= '0;
      imm_ext     <= '0;
      alu_src_imm <= 1'b0;
      reg_waddr   <= '0;
      k_lw        <= 1'b0;
      k_sw        <= 1'b0;
      k_jr        <= 1'b0;
      k_nop       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && instr_valid) instr_q <= instr;
      if (state == DECODE) begin
        alu_op      <= d_op;
        shamt       <= instr_q[10:6];
        rs_addr     <= instr_q[25:21];
        rt_addr     <= instr_q[20:16];
        imm_ext     <= d_imm;
        alu_src_imm <= d_src;
        reg_waddr   <= d_waddr;
        k_lw        <= d_lw;
        k_sw        <= d_sw;
        k_jr        <= d_jr;
        k_nop       <= d_nop;
      end
    end
  end

  // strobes are pure state decodes so an async reset clears them at once
  assign instr_ready = (state == FETCH) && rst_n;
  assign mem_rd      = (state == MEM) && k_lw;
  assign mem_wr      = (state == MEM) && k_sw;
  assign reg_we      = (state == WB) && (reg_waddr != 5'd0);
  assign pc_jr       = (state == EXEC) && k_jr;
  assign illegal     = (state == DECODE) && d_ill;
  assign instr_done  = (state == WB)
                     || ((state == EXEC) && (k_jr || k_nop))
                     || ((state == MEM) && k_sw && mem_ack);

endmodule

// File: tb/tb_mips_alu_ctrl_fsm.sv
// Directed bench for mips_alu_ctrl_fsm: per-cycle checks of decode
// fields and control strobes for each instruction class.
module tb_mips_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  alu_op, shamt, rs_addr, rt_addr, reg_waddr;
  logic [31:0] imm_ext;
  logic        alu_src_imm, mem_rd, mem_wr, mem_ack;
  logic        reg_we, pc_jr, instr_done, illegal;

  int n_chk = 0;
  int n_err = 0;

  mips_alu_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_op(alu_op), .shamt(shamt),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .imm_ext(imm_ext), .alu_src_imm(alu_src_imm),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .reg_we(reg_we), .reg_waddr(reg_waddr),
    .pc_jr(pc_jr), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // present word in cycle 0; returns at the negedge of cycle 1 (DECODE)
  task automatic issue(input logic [31:0] w);
    @(negedge clk);
    chk("ready_c0", 32'(instr_ready), 1);
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 32'hFFFF_FFFF;
  endtask

  initial begin
    rst_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    #23;
    chk("rst_alu_op", 32'(alu_op), 12);
    chk("rst_reg_we", 32'(reg_we), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_imm", imm_ext, 0);
    chk("rst_done", 32'(instr_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(instr_ready), 1);

    // add $3,$1,$2
    issue(32'h0022_1820);
    chk("add_ill", 32'(illegal), 0);
    @(negedge clk);
    chk("add_op", 32'(alu_op), 0);
    chk("add_rs", 32'(rs_addr), 1);
    chk("add_rt", 32'(rt_addr), 2);
    chk("add_src", 32'(alu_src_imm), 0);
    chk("add_we_c2", 32'(reg_we), 0);
    @(negedge clk);
    chk("add_we", 32'(reg_we), 1);
    chk("add_wa", 32'(reg_waddr), 3);
    chk("add_done", 32'(instr_done), 1);

    // addi $5,$0,-4
    issue(32'h2005_FFFC);
    @(negedge clk);
    chk("addi_op", 32'(alu_op), 16);
    chk("addi_imm", imm_ext, 32'hFFFF_FFFC);
    chk("addi_src", 32'(alu_src_imm), 1);
    @(negedge clk);
    chk("addi_we", 32'(reg_we), 1);
    chk("addi_wa", 32'(reg_waddr), 5);

    // ori $6,$0,0x8000
    issue(32'h3406_8000);
    @(negedge clk);
    chk("ori_op", 32'(alu_op), 14);
    chk("ori_imm", imm_ext, 32'h0000_8000);
    @(negedge clk);
    chk("ori_wa", 32'(reg_waddr), 6);

    // lw $4,8($2), ack in EXEC ignored, real ack 3 cycles into MEM
    issue(32'h8C44_0008);
    @(negedge clk);
    chk("lw_op", 32'(alu_op), 18);
    chk("lw_imm", imm_ext, 32'h8);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = (i == 2);
      chk("lw_rd", 32'(mem_rd), 1);
      chk("lw_we0", 32'(reg_we), 0);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk("lw_rd_off", 32'(mem_rd), 0);
    chk("lw_we", 32'(reg_we), 1);
    chk("lw_wa", 32'(reg_waddr), 4);
    chk("lw_done", 32'(instr_done), 1);

    // sw $4,8($2), ack on MEM entry
    issue(32'hAC44_0008);
    @(negedge clk);
    chk("sw_op", 32'(alu_op), 19);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk("sw_wr", 32'(mem_wr), 1);
    chk("sw_rd", 32'(mem_rd), 0);
    chk("sw_done", 32'(instr_done), 1);
    chk("sw_we", 32'(reg_we), 0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("sw_wr_off", 32'(mem_wr), 0);

    // jr $31
    issue(32'h03E0_0008);
    @(negedge clk);
    chk("jr_op", 32'(alu_op), 11);
    chk("jr_pc", 32'(pc_jr), 1);
    chk("jr_done", 32'(instr_done), 1);
    @(negedge clk);
    chk("jr_pc_off", 32'(pc_jr), 0);
    chk("jr_we", 32'(reg_we), 0);

    // nop
    issue(32'h0000_0000);
    @(negedge clk);
    chk("nop_op", 32'(alu_op), 12);
    chk("nop_done", 32'(instr_done), 1);
    chk("nop_pc", 32'(pc_jr), 0);
    @(negedge clk);
    chk("nop_we", 32'(reg_we), 0);

    // sll $0,$0,1: WB visited, write suppressed
    issue(32'h0000_0040);
    @(negedge clk);
    chk("sll_op", 32'(alu_op), 8);
    chk("sll_sh", 32'(shamt), 1);
    @(negedge clk);
    chk("sll_we", 32'(reg_we), 0);
    chk("sll_done", 32'(instr_done), 1);

    // opcode 0x3F
    issue(32'hFC00_0000);
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_rd", 32'(mem_rd), 0);
    @(negedge clk);
    chk("ill_off", 32'(illegal), 0);
    chk("ill_ready", 32'(instr_ready), 1);
    chk("ill_we", 32'(reg_we), 0);

    // reset during MEM
    issue(32'h8C44_0008);
    @(negedge clk);
    @(negedge clk);
    chk("rm_rd_pre", 32'(mem_rd), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_rd", 32'(mem_rd), 0);
    chk("rm_op", 32'(alu_op), 12);
    chk("rm_done", 32'(instr_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rm_ready", 32'(instr_ready), 1);

    // normal operation after reset
    issue(32'h0022_1820);
    @(negedge clk);
    chk("post_op", 32'(alu_op), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
